// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: shared definitions for the multiplexed hex display driver.
//   scan_state_t : scan FSM states
//   NUM_DIGITS   : number of multiplexed digits
//   AN_OFF       : anode pattern with every digit dark (anodes are active-low)
//   lz_blank()   : leading-zero blank decision for a digit slot
package hex_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  // A digit above position 0 is blanked when it and every nibble above it
  // are zero. Digit 0 always shows, so a value of zero still reads "0".
  function automatic logic lz_blank(input logic [15:0] sh,
                                    input logic [1:0]  idx,
                                    input logic        en);
    logic upper_zero;
    case (idx)
      2'd1:    upper_zero = (sh[15:4]  == 12'h000);
      2'd2:    upper_zero = (sh[15:8]  == 8'h00);
      2'd3:    upper_zero = (sh[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
    return en && upper_zero;
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// refresh_prescaler: free-running slot timer for the display scan.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : high for the one cycle in which the count sits at PRESCALE_MAX
// The count runs 0..PRESCALE_MAX and wraps; nothing but reset stops it.
module refresh_prescaler #(
  parameter int PRESCALE_MAX = 99999,
  parameter int PRESCALE_W   = 17
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] CNT_MAX = PRESCALE_W'(PRESCALE_MAX);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hex_scan_driver.sv
// hex_scan_driver: scans a 16-bit shadow value onto a shared hex nibble bus,
// one digit per refresh slot, with active-low digit anodes.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   load, value    : shadow capture strobe and 16-bit display value
//   blank_lz       : leading-zero suppression enable, sampled at slot start
//   D3..D0         : nibble of the digit currently presented
//   AN             : active-low digit anodes, at most one low
//   digit_idx      : index of the digit on D3..D0
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | after reset, anodes off, waiting for the first slot tick
//   ST_GUARD | slot start, anodes off while the new nibble settles
//   ST_DRIVE | selected anode on (unless blanked) until the next tick
module hex_scan_driver #(
  parameter int PRESCALE_MAX = 99999,
  parameter int PRESCALE_W   = 17,
  parameter int GUARD_CYC    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic        D0,
  output logic        D1,
  output logic        D2,
  output logic        D3,
  output logic [3:0]  AN,
  output logic [1:0]  digit_idx
);

  import hex_disp_pkg::*;

  // Guard counter is loaded on the tick edge, so GUARD_CYC-1 more clocks
  // are spent in GUARD after the one that the tick edge itself starts.
  localparam logic [PRESCALE_W-1:0] GUARD_LOAD = PRESCALE_W'(GUARD_CYC - 1);

  logic                  tick;
  scan_state_t           state_q, state_d;
  logic [15:0]           shadow_q, shadow_d;
  logic [1:0]            idx_q, idx_d;
  logic [3:0]            nib_q, nib_d;
  logic [3:0]            an_q, an_d;
  logic                  blank_q, blank_d;
  logic [PRESCALE_W-1:0] guard_q, guard_d;
  logic                  slot_start;

  refresh_prescaler #(
    .PRESCALE_MAX (PRESCALE_MAX),
    .PRESCALE_W   (PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    nib_d      = nib_q;
    blank_d    = blank_q;
    guard_d    = guard_q;
    slot_start = 1'b0;
    shadow_d   = load ? value : shadow_q;

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          slot_start = 1'b1;
          idx_d      = 2'd0;
        end
      end
      ST_GUARD: begin
        if (tick) begin
          slot_start = 1'b1;
          idx_d      = idx_q + 2'd1;
        end else if (guard_q == '0) begin
          state_d = ST_DRIVE;
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
      ST_DRIVE: begin
        if (tick) begin
          slot_start = 1'b1;
          idx_d      = idx_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Nibble and blank flag come from the shadow as it stands before the
    // tick edge, so a load on that same edge only shows from the next slot.
    if (slot_start) begin
      state_d = ST_GUARD;
      guard_d = GUARD_LOAD;
      nib_d   = shadow_q[4*idx_d +: 4];
      blank_d = lz_blank(shadow_q, idx_d, blank_lz);
    end

    // Anodes are decoded from next-state values so they stay registered.
    if (state_d == ST_DRIVE && !blank_d) an_d = ~(4'b0001 << idx_d);
    else                                 an_d = AN_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shadow_q <= 16'h0000;
      idx_q    <= 2'd0;
      nib_q    <= 4'h0;
      an_q     <= AN_OFF;
      blank_q  <= 1'b0;
      guard_q  <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      nib_q    <= nib_d;
      an_q     <= an_d;
      blank_q  <= blank_d;
      guard_q  <= guard_d;
    end
  end

  assign D0        = nib_q[0];
  assign D1        = nib_q[1];
  assign D2        = nib_q[2];
  assign D3        = nib_q[3];
  assign AN        = an_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// tb_hex_scan_driver: directed bench for hex_scan_driver with a 4-clock slot
// (PRESCALE_MAX=3) and a 1-clock guard. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_hex_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic        D0, D1, D2, D3;
  logic [3:0]  AN;
  logic [1:0]  digit_idx;

  int checks = 0;
  int errors = 0;

  hex_scan_driver #(
    .PRESCALE_MAX (3),
    .PRESCALE_W   (2),
    .GUARD_CYC    (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .value     (value),
    .blank_lz  (blank_lz),
    .D0        (D0),
    .D1        (D1),
    .D2        (D2),
    .D3        (D3),
    .AN        (AN),
    .digit_idx (digit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] an_e,
                     input logic [3:0] nib_e, input logic [1:0] idx_e);
    logic [3:0] nib;
    nib = {D3, D2, D1, D0};
    checks++;
    assert (AN === an_e) else begin
      errors++;
      $error("FAIL %s AN=%b expected %b", tag, AN, an_e);
    end
    checks++;
    assert (nib === nib_e) else begin
      errors++;
      $error("FAIL %s D=%h expected %h", tag, nib, nib_e);
    end
    checks++;
    assert (digit_idx === idx_e) else begin
      errors++;
      $error("FAIL %s digit_idx=%0d expected %0d", tag, digit_idx, idx_e);
    end
  endtask

  // Called on the falling edge just before a tick edge; returns on the
  // falling edge just before the following tick edge.
  task automatic check_slot(input string tag, input logic [1:0] idx_e,
                            input logic [3:0] nib_e, input logic [3:0] an_e);
    @(negedge clk); chk({tag, "_guard"}, 4'b1111, nib_e, idx_e);
    @(negedge clk); chk({tag, "_drive"}, an_e, nib_e, idx_e);
    @(negedge clk);
    @(negedge clk); chk({tag, "_end"}, an_e, nib_e, idx_e);
  endtask

  task automatic startup(input string tag);
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk); chk({tag, "_idle"}, 4'b1111, 4'h0, 2'd0);
    end
    @(negedge clk); chk({tag, "_guard0"}, 4'b1111, 4'h0, 2'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = 16'h0000;
    blank_lz = 1'b0;

    // Reset held for 5 clocks
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("in_reset", 4'b1111, 4'h0, 2'd0);
    end
    rst_n = 1'b1;
    startup("start");

    // Load 4A3C during the first slot; it is shown from the next slot on
    load = 1'b1; value = 16'h4A3C;
    @(negedge clk); chk("first_drive", 4'b1110, 4'h0, 2'd0);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_slot("scan1", 2'd1, 4'h3, 4'b1101);
    check_slot("scan2", 2'd2, 4'hA, 4'b1011);
    check_slot("scan3", 2'd3, 4'h4, 4'b0111);
    check_slot("scan0", 2'd0, 4'hC, 4'b1110);
    check_slot("wrap1", 2'd1, 4'h3, 4'b1101);

    // Load 2222 on a tick edge: that slot still shows 4A3C
    load = 1'b1; value = 16'h2222;
    @(negedge clk); chk("ld2_tick", 4'b1111, 4'hA, 2'd2);
    load = 1'b0;
    @(negedge clk); chk("ld2_drive", 4'b1011, 4'hA, 2'd2);
    @(negedge clk);
    @(negedge clk);
    // Load 1111 on the next tick edge while shadow holds 2222
    load = 1'b1; value = 16'h1111;
    @(negedge clk); chk("ld1_tick", 4'b1111, 4'h2, 2'd3);
    load = 1'b0;
    @(negedge clk); chk("ld1_drive", 4'b0111, 4'h2, 2'd3);
    @(negedge clk);
    @(negedge clk);
    check_slot("ones0", 2'd0, 4'h1, 4'b1110);
    check_slot("ones1", 2'd1, 4'h1, 4'b1101);

    // Leading-zero blanking of 0050
    load = 1'b1; value = 16'h0050; blank_lz = 1'b1;
    @(negedge clk); chk("lz_tick", 4'b1111, 4'h1, 2'd2);
    load = 1'b0;
    @(negedge clk); chk("lz_old", 4'b1011, 4'h1, 2'd2);
    @(negedge clk);
    @(negedge clk);
    check_slot("lz50_d3", 2'd3, 4'h0, 4'b1111);
    check_slot("lz50_d0", 2'd0, 4'h0, 4'b1110);
    check_slot("lz50_d1", 2'd1, 4'h5, 4'b1101);
    check_slot("lz50_d2", 2'd2, 4'h0, 4'b1111);
    check_slot("lz50_d3b", 2'd3, 4'h0, 4'b1111);

    // Value 0000 with blanking: only digit 0 lit
    load = 1'b1; value = 16'h0000;
    @(negedge clk); chk("lz0_tick", 4'b1111, 4'h0, 2'd0);
    load = 1'b0;
    @(negedge clk); chk("lz0_drive0", 4'b1110, 4'h0, 2'd0);
    @(negedge clk);
    @(negedge clk);
    check_slot("lz0_d1", 2'd1, 4'h0, 4'b1111);
    check_slot("lz0_d2", 2'd2, 4'h0, 4'b1111);
    check_slot("lz0_d3", 2'd3, 4'h0, 4'b1111);
    check_slot("lz0_d0", 2'd0, 4'h0, 4'b1110);

    // Reload 4A3C without blanking, then reset asynchronously during digit 2
    load = 1'b1; value = 16'h4A3C; blank_lz = 1'b0;
    @(negedge clk); chk("rl_tick", 4'b1111, 4'h0, 2'd1);
    load = 1'b0;
    @(negedge clk); chk("rl_drive", 4'b1101, 4'h0, 2'd1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); chk("pre_rst_guard", 4'b1111, 4'hA, 2'd2);
    @(negedge clk); chk("pre_rst_drive", 4'b1011, 4'hA, 2'd2);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 4'b1111, 4'h0, 2'd0);
    @(negedge clk); chk("async_hold", 4'b1111, 4'h0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    startup("restart");
    @(negedge clk); chk("restart_drive", 4'b1110, 4'h0, 2'd0);
    @(negedge clk);
    @(negedge clk);
    check_slot("restart_d1", 2'd1, 4'h0, 4'b1101);
    check_slot("restart_d2", 2'd2, 4'h0, 4'b1011);

    // Random loads and blank_lz: anodes never have more than one bit low
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      checks++;
      assert ($onehot0(~AN) === 1'b1) else begin
        errors++;
        $error("FAIL an_onehot cycle %0d AN=%b expected at most one low", i, AN);
      end
      load     = ($urandom_range(0, 3) == 0);
      value    = 16'($urandom);
      blank_lz = 1'($urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_scan_driver.md
Name: hex_scan_driver

Overview:
- Upstream feeder for the single-segment decoders (segment_a … segment_g). All seven decoders share its D3..D0 nibble outputs.
- Holds a 16-bit value captured with a load strobe. Time-multiplexes four hex digits onto the shared nibble and drives active-low digit anodes.
- Adds a blanking guard between digits to prevent ghosting, plus optional leading-zero suppression.

Parameters:
- PRESCALE_MAX, 99999: terminal count of the refresh prescaler. Slot length is PRESCALE_MAX+1 clocks per digit.
- PRESCALE_W, 17: prescaler width. Must satisfy 2^PRESCALE_W > PRESCALE_MAX.
- GUARD_CYC, 2: clocks of all-anodes-off at the start of each slot. Range 1..PRESCALE_MAX.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  capture strobe; value is sampled on every clk edge where load=1.
- value  in  16  display value; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- blank_lz  in  1  1 = suppress leading zeros. Sampled each slot start.
- D0  out  1  nibble bit 0 to decoders.
- D1  out  1  nibble bit 1.
- D2  out  1  nibble bit 2.
- D3  out  1  nibble bit 3.
- AN  out  4  digit anodes, active-low, at most one bit low.
- digit_idx  out  2  index of the digit currently presented on D3..D0.

Behaviour:
- Reset state:
  - shadow=16'h0000, prescaler=0, digit_idx=0.
  - D3..D0=0, AN=4'b1111, FSM=IDLE.
  - Reset asserted mid-operation forces these values immediately, asynchronously.
- Outputs: all registered; no combinational path from inputs to outputs.
- Prescaler:
  - Counts 0..PRESCALE_MAX, then wraps to 0.
  - tick=1 in the cycle where count==PRESCALE_MAX.
- FSM states: IDLE, GUARD, DRIVE.
  - IDLE: AN=1111. On tick, set digit_idx=0 and go to GUARD. The first tick after reset release arrives PRESCALE_MAX+1 clocks later.
  - GUARD: AN=1111, D3..D0 already hold the new digit's nibble. Stays GUARD_CYC clocks, counted from the tick edge, then goes to DRIVE.
  - DRIVE:
    - AN[digit_idx]=0 and all other bits 1, unless the digit is blanked (then AN=1111).
    - On tick, set digit_idx=digit_idx+1 (3 wraps to 0), load the new nibble, go to GUARD.
- Slot timing: each slot is PRESCALE_MAX+1 clocks, of which GUARD_CYC are guard and the rest are drive. Full refresh = 4 slots.
- Nibble selection:
  - At the tick edge, D3..D0 <= shadow[4*i+3:4*i], where i is the new digit_idx.
  - Uses the shadow contents as they stand before that edge.
- Load:
  - shadow <= value on any edge with load=1, in any state, including IDLE.
  - Displayed nibbles change only at slot starts. There is no mid-slot tearing.
  - load coincident with tick: the new slot shows the old shadow; the new value appears from the next slot.
  - Back-to-back loads: the last one wins.
- Leading-zero blank:
  - Evaluated at slot start against the same shadow used for the nibble.
  - With blank_lz=1 and i>0, the digit is blanked if shadow nibbles i..3 are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - A blanked digit keeps AN=1111 for the entire slot, but D3..D0 and digit_idx still update.
- Prescaler never stalls. load and blank_lz do not reset it.

Decomposition:
- Shared package hex_disp_pkg:
  - FSM state enum (IDLE, GUARD, DRIVE).
  - NUM_DIGITS=4.
  - Anode-off constant 4'b1111.
- Natural sub-module: refresh_prescaler, with parameters PRESCALE_MAX and PRESCALE_W, inputs clk and rst_n, output tick.
- Remainder (shadow register, FSM, digit mux, blank logic) stays in hex_scan_driver.

Test Plan (bench uses PRESCALE_MAX=3, GUARD_CYC=1; slot = 4 clocks):
- Reset check: hold rst_n=0 for 5 clocks, then release.
  - Required: AN=1111 and D=0 during reset and for 4 clocks after.
  - Then digit_idx=0 with AN=1111 for 1 clock, then AN=1110.
- Scan order: load value=16'h4A3C, blank_lz=0, observe 4 slots.
  - Required nibbles 0xC, 0x3, 0xA, 0x4 with AN 1110, 1101, 1011, 0111 in DRIVE.
  - Required AN=1111 on the first clock of each slot. Sequence then wraps to idx 0.
- Load coincident with tick: pulse load with 16'h1111 on the tick edge while shadow=16'h2222.
  - Required: the next slot shows 0x2; subsequent slots show 0x1.
- Leading-zero blank: value=16'h0050, blank_lz=1.
  - Required: digit 0 lit with 0x0, digit 1 lit with 0x5, digits 2 and 3 AN=1111 for the whole slot.
  - value=16'h0000: only digit 0 lit.
- Async reset mid-DRIVE: drop rst_n between clock edges during digit 2.
  - Required: AN=1111, D=0, digit_idx=0 immediately, without waiting for a clock edge.
  - After release: shadow=0 and the startup sequence repeats.
- Invariant: across a 10 000-cycle random load/blank_lz run, AN always has at most one bit low.
